// File: rtl/asteroid_pkg.sv
// Shared definitions for the asteroid spawner.
//   - DIR_* : 3-bit compass directions, 0 = N (towards -y), stepping clockwise
//   - edge_e: screen edge picked by a draw
//   - state_e: spawner FSM states
package asteroid_pkg;

    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    typedef enum logic [1:0] {
        EDGE_TOP    = 2'd0,
        EDGE_RIGHT  = 2'd1,
        EDGE_BOTTOM = 2'd2,
        EDGE_LEFT   = 2'd3
    } edge_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shifting Galois LFSR with synchronous seed load.
// Ports:
//   iClk   in  1  clock
//   iRst   in  1  asynchronous reset, active low (state := SEED)
//   iLoad  in  1  load iSeed this cycle instead of stepping
//   iSeed  in  W  seed; an all-zero seed is replaced by SEED so the LFSR never locks up
//   oState out W  current LFSR state
module lfsr_galois #(
    parameter int unsigned    W    = 16,
    parameter logic [W-1:0]   TAPS = 16'hB400,
    parameter logic [W-1:0]   SEED = 16'hACE1
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iLoad,
    input  logic [W-1:0] iSeed,
    output logic [W-1:0] oState
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        if (iLoad) begin
            state_d = (iSeed == '0) ? SEED : iSeed;
        end else if (state_q[0]) begin
            state_d = (state_q >> 1) ^ TAPS;
        end else begin
            state_d = state_q >> 1;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign oState = state_q;

endmodule

// File: rtl/asteroid_spawner.sv
// Spawn-point generator for asteroids. On a request it draws a random screen edge, a position
// along that edge clear of the corner margins, an inward diagonal direction and a size, then
// holds the result on a valid/ready handshake. Draws landing in a margin are retried up to
// RETRY_MAX times; after that the edge midpoint is used and oFallback is raised.
// Ports:
//   iClk      in   1        clock
//   iRst      in   1        asynchronous reset, active low
//   iSeedLoad in   1        load iSeed into the LFSR (any state)
//   iSeed     in   LFSR_W   seed value; 0 is replaced by SEED
//   iReq      in   1        spawn request level, sampled only in IDLE
//   oValid    out  1        spawn result valid
//   iReady    in   1        consumer accepts when oValid & iReady
//   oPosX     out  COORD_W  spawn x
//   oPosY     out  COORD_W  spawn y
//   oDir      out  3        direction (see asteroid_pkg DIR_*)
//   oSize     out  2        size, clamped to >= MIN_SIZE
//   oFallback out  1        result is the retry fallback midpoint
module asteroid_spawner
    import asteroid_pkg::*;
#(
    parameter int unsigned       SCREEN_W  = 640,
    parameter int unsigned       SCREEN_H  = 480,
    parameter int unsigned       COORD_W   = 11,
    parameter int unsigned       MARGIN    = 40,
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int unsigned       RETRY_MAX = 7,
    parameter int unsigned       MIN_SIZE  = 1
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iSeedLoad,
    input  logic [LFSR_W-1:0]  iSeed,
    input  logic               iReq,
    output logic               oValid,
    input  logic               iReady,
    output logic [COORD_W-1:0] oPosX,
    output logic [COORD_W-1:0] oPosY,
    output logic [2:0]         oDir,
    output logic [1:0]         oSize,
    output logic               oFallback
);

    localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [RETRY_W-1:0] RETRY_C = RETRY_W'(RETRY_MAX);
    localparam logic [COORD_W-1:0] W_C     = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] H_C     = COORD_W'(SCREEN_H);
    localparam logic [COORD_W-1:0] M_C     = COORD_W'(MARGIN);
    localparam logic [COORD_W-1:0] W_HI    = COORD_W'(SCREEN_W - MARGIN);
    localparam logic [COORD_W-1:0] H_HI    = COORD_W'(SCREEN_H - MARGIN);
    localparam logic [COORD_W-1:0] W_MID   = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0] H_MID   = COORD_W'(SCREEN_H / 2);
    localparam logic [1:0]         MIN_SZ  = 2'(MIN_SIZE);

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    logic [LFSR_W-1:0] lfsr;

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .iClk   (iClk),
        .iRst   (iRst),
        .iLoad  (iSeedLoad),
        .iSeed  (iSeed),
        .oState (lfsr)
    );

    edge_e              edge_sel;
    logic               dsel;
    logic [1:0]         size_raw;
    logic [COORD_W-1:0] along;

    assign edge_sel = edge_e'(lfsr[1:0]);
    assign dsel     = lfsr[2];
    assign size_raw = lfsr[4:3];
    assign along    = lfsr[LFSR_W-1 -: COORD_W];

    // ------------------------------------------------------------------
    // Draw evaluation: rejection test and edge/direction mapping
    // ------------------------------------------------------------------
    logic               side_edge;
    logic               reject;
    logic [COORD_W-1:0] along_eff;
    logic [COORD_W-1:0] pos_x_d;
    logic [COORD_W-1:0] pos_y_d;
    logic [2:0]         dir_d;
    logic [1:0]         size_d;

    assign side_edge = (edge_sel == EDGE_RIGHT) || (edge_sel == EDGE_LEFT);

    always_comb begin
        reject = (along < M_C) || (along >= (side_edge ? H_HI : W_HI));

        // A rejected draw only reaches the result registers once retries are exhausted,
        // so substituting the midpoint here is exactly the fallback case.
        along_eff = along;
        if (reject) begin
            along_eff = side_edge ? H_MID : W_MID;
        end

        pos_x_d = '0;
        pos_y_d = '0;
        dir_d   = DIR_SE;
        unique case (edge_sel)
            EDGE_TOP: begin
                pos_x_d = along_eff;
                pos_y_d = '0;
                dir_d   = dsel ? DIR_SW : DIR_SE;
            end
            EDGE_RIGHT: begin
                pos_x_d = W_C;
                pos_y_d = along_eff;
                dir_d   = dsel ? DIR_NW : DIR_SW;
            end
            EDGE_BOTTOM: begin
                pos_x_d = along_eff;
                pos_y_d = H_C;
                dir_d   = dsel ? DIR_NE : DIR_NW;
            end
            EDGE_LEFT: begin
                pos_x_d = '0;
                pos_y_d = along_eff;
                dir_d   = dsel ? DIR_SE : DIR_NE;
            end
        endcase

        size_d = (size_raw < MIN_SZ) ? MIN_SZ : size_raw;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_e               state_q;
    state_e               state_d;
    logic [RETRY_W-1:0]   retry_q;
    logic [RETRY_W-1:0]   retry_d;
    logic                 load_result;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= IDLE;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        load_result = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iReq) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (reject && (retry_q < RETRY_C)) begin
                    retry_d = retry_q + 1'b1;
                end else begin
                    state_d     = HOLD;
                    load_result = 1'b1;
                end
            end
            HOLD: begin
                if (iReady) begin
                    state_d = IDLE;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers: captured once when leaving DRAW, stable through HOLD
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] pos_x_q;
    logic [COORD_W-1:0] pos_y_q;
    logic [2:0]         dir_q;
    logic [1:0]         size_q;
    logic               fallback_q;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            dir_q      <= '0;
            size_q     <= '0;
            fallback_q <= 1'b0;
        end else if (load_result) begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_q      <= dir_d;
            size_q     <= size_d;
            fallback_q <= reject;
        end
    end

    always_comb begin
        oValid    = (state_q == HOLD);
        oPosX     = pos_x_q;
        oPosY     = pos_y_q;
        oDir      = dir_q;
        oSize     = size_q;
        oFallback = fallback_q;
    end

endmodule

// File: tb/tb_asteroid_spawner.sv
// Self-checking bench for asteroid_spawner: randomized spawns compared against a behavioural
// model that replays the draw rules on a shadow LFSR, plus spec-level property checks.
module tb_asteroid_spawner;

    localparam int          SW        = 640;
    localparam int          SH        = 480;
    localparam int          MARGIN    = 40;
    localparam int          RETRY_MAX = 7;
    localparam int          MIN_SIZE  = 1;
    localparam int          N_B2B     = 10000;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam logic [15:0] TAPS      = 16'hB400;

    logic        iClk      = 1'b0;
    logic        iRst      = 1'b0;
    logic        iSeedLoad = 1'b0;
    logic [15:0] iSeed     = '0;
    logic        iReq      = 1'b0;
    logic        iReady    = 1'b0;
    logic        oValid;
    logic [10:0] oPosX;
    logic [10:0] oPosY;
    logic [2:0]  oDir;
    logic [1:0]  oSize;
    logic        oFallback;

    int errors = 0;
    int checks = 0;

    bit edge_hit[4];
    bit pair_hit[4][8];

    typedef struct {
        int n;      // DRAW cycles consumed
        int x;
        int y;
        int dir;
        int size;
        bit fb;
    } spawn_t;

    asteroid_spawner dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iSeedLoad (iSeedLoad),
        .iSeed     (iSeed),
        .iReq      (iReq),
        .oValid    (oValid),
        .iReady    (iReady),
        .oPosX     (oPosX),
        .oPosY     (oPosY),
        .oDir      (oDir),
        .oSize     (oSize),
        .oFallback (oFallback)
    );

    always #5 iClk = ~iClk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Shadow of the free-running random source
    logic [15:0] m_lfsr;
    always @(posedge iClk or negedge iRst) begin
        if (!iRst)          m_lfsr <= SEED;
        else if (iSeedLoad) m_lfsr <= (iSeed == 16'h0) ? SEED : iSeed;
        else                m_lfsr <= step(m_lfsr);
    end

    // Replay the draw rules starting from the LFSR value seen in the first DRAW cycle
    function automatic spawn_t predict(input logic [15:0] l0);
        spawn_t r;
        logic [15:0] l;
        int e, along, len, d;
        bit done;
        l = l0;
        done = 0;
        r = '{0, 0, 0, 0, 0, 0};
        for (int k = 0; k <= RETRY_MAX && !done; k++) begin
            e     = int'(l[1:0]);
            d     = int'(l[2]);
            along = int'(l[15:5]);
            len   = (e % 2 == 0) ? SW : SH;
            if ((along >= MARGIN && along < len - MARGIN) || k == RETRY_MAX) begin
                r.fb = !(along >= MARGIN && along < len - MARGIN);
                if (r.fb) along = len / 2;
                case (e)
                    0:       begin r.x = along; r.y = 0;     end
                    1:       begin r.x = SW;    r.y = along; end
                    2:       begin r.x = along; r.y = SH;    end
                    default: begin r.x = 0;     r.y = along; end
                endcase
                r.dir  = (3 + 2 * e + 2 * d) % 8;
                r.size = (int'(l[4:3]) < MIN_SIZE) ? MIN_SIZE : int'(l[4:3]);
                r.n    = k + 1;
                done   = 1;
            end else begin
                l = step(l);
            end
        end
        return r;
    endfunction

    function automatic bit out_match(input spawn_t e);
        return (oPosX === 11'(e.x)) && (oPosY === 11'(e.y)) && (oDir === 3'(e.dir)) &&
               (oSize === 2'(e.size)) && (oFallback === e.fb);
    endfunction

    function automatic bit outs_zero();
        return (oValid === 1'b0) && (oPosX === 11'd0) && (oPosY === 11'd0) &&
               (oDir === 3'd0) && (oSize === 2'd0) && (oFallback === 1'b0);
    endfunction

    // Which edge a point lies on, clear of the corner margins; -1 if none
    function automatic int edge_of(input int x, input int y);
        if (y == 0  && x >= MARGIN && x < SW - MARGIN) return 0;
        if (x == SW && y >= MARGIN && y < SH - MARGIN) return 1;
        if (y == SH && x >= MARGIN && x < SW - MARGIN) return 2;
        if (x == 0  && y >= MARGIN && y < SH - MARGIN) return 3;
        return -1;
    endfunction

    function automatic int dir_dx(input int d);
        case (d)
            1, 2, 3: return 1;
            5, 6, 7: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dir_dy(input int d);
        case (d)
            7, 0, 1: return -1;
            3, 4, 5: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit inward(input int e, input int d);
        if (dir_dx(d) == 0 || dir_dy(d) == 0) return 0;
        case (e)
            0:       return dir_dy(d) > 0;
            1:       return dir_dx(d) < 0;
            2:       return dir_dy(d) < 0;
            default: return dir_dx(d) > 0;
        endcase
    endfunction

    // Entry: #1 after the edge at which the DUT entered DRAW. Exit: #1 after the edge that
    // completed the handshake (DUT back in IDLE).
    task automatic run_spawn(input int hold, input bit seed_in_hold, input string tag);
        spawn_t e;
        int lat;
        int pe;
        e = predict(m_lfsr);
        lat = 0;
        while (oValid !== 1'b1 && lat <= RETRY_MAX + 2) begin
            @(posedge iClk); #1;
            lat++;
        end
        checks++;
        if (lat != e.n) begin
            errors++;
            $display("FAIL %s latency: got %0d draw cycles, expected %0d", tag, lat, e.n);
        end
        checks++;
        if (!out_match(e)) begin
            errors++;
            $display("FAIL %s result: got x=%0d y=%0d dir=%0d size=%0d fb=%b, expected x=%0d y=%0d dir=%0d size=%0d fb=%b",
                     tag, oPosX, oPosY, oDir, oSize, oFallback, e.x, e.y, e.dir, e.size, e.fb);
        end
        pe = edge_of(int'(oPosX), int'(oPosY));
        checks++;
        if (pe < 0 || !inward(pe, int'(oDir)) || int'(oSize) < MIN_SIZE) begin
            errors++;
            $display("FAIL %s props: got x=%0d y=%0d dir=%0d size=%0d, expected on-edge inward size>=%0d",
                     tag, oPosX, oPosY, oDir, oSize, MIN_SIZE);
        end else begin
            edge_hit[pe] = 1;
            pair_hit[pe][int'(oDir)] = 1;
        end
        for (int i = 0; i < hold; i++) begin
            iReady = 1'b0;
            iReq   = 1'($urandom_range(0, 1));
            @(posedge iClk); #1;
            checks++;
            if (oValid !== 1'b1 || !out_match(e)) begin
                errors++;
                $display("FAIL %s hold_stable cycle %0d: got valid=%b x=%0d y=%0d dir=%0d, expected valid=1 x=%0d y=%0d dir=%0d",
                         tag, i, oValid, oPosX, oPosY, oDir, e.x, e.y, e.dir);
            end
        end
        if (seed_in_hold) begin
            iSeedLoad = 1'b1;
            iSeed     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        end
        if (hold > 0) iReq = 1'b0;
        iReady = 1'b1;
        @(posedge iClk); #1;
        iSeedLoad = 1'b0;
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got valid=%b, expected 0 after handshake", tag, oValid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        iRst = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d dir=%0d size=%0d fb=%b, expected all 0",
                     oValid, oPosX, oPosY, oDir, oSize, oFallback);
        end
        checks++;
        if (dut.u_lfsr.oState !== SEED) begin
            errors++;
            $display("FAIL reset_lfsr: got %h, expected %h", dut.u_lfsr.oState, SEED);
        end
        iRst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            iReady = 1'($urandom_range(0, 1));
            @(posedge iClk); #1;
            checks++;
            if (!outs_zero()) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: got valid=%b x=%0d y=%0d dir=%0d size=%0d fb=%b, expected all 0",
                         i, oValid, oPosX, oPosY, oDir, oSize, oFallback);
            end
        end
        iReady = 1'b0;
    endtask

    task automatic test_seed_load();
        logic [15:0] s;
        iSeedLoad = 1'b1;
        iSeed     = 16'h0000;
        @(posedge iClk); #1;
        iSeedLoad = 1'b0;
        checks++;
        if (dut.u_lfsr.oState !== 16'hACE1) begin
            errors++;
            $display("FAIL seed_zero: got %h, expected ace1", dut.u_lfsr.oState);
        end
        s = 16'($urandom_range(1, 65535));
        iSeedLoad = 1'b1;
        iSeed     = s;
        @(posedge iClk); #1;
        iSeedLoad = 1'b0;
        checks++;
        if (dut.u_lfsr.oState !== s) begin
            errors++;
            $display("FAIL seed_value: got %h, expected %h", dut.u_lfsr.oState, s);
        end
        @(posedge iClk); #1;
        checks++;
        if (dut.u_lfsr.oState !== step(s)) begin
            errors++;
            $display("FAIL seed_step: got %h, expected %h", dut.u_lfsr.oState, step(s));
        end
    endtask

    task automatic test_handshake();
        iReq   = 1'b1;
        iReady = 1'b0;
        @(posedge iClk); #1;
        iReq = 1'b0;
        run_spawn(20, 1'b0, "handshake");
        iReady = 1'b0;
        // Requests seen only while busy must not have been queued
        for (int i = 0; i < 5; i++) begin
            @(posedge iClk); #1;
            checks++;
            if (oValid !== 1'b0) begin
                errors++;
                $display("FAIL no_queue cycle %0d: got valid=%b, expected 0", i, oValid);
            end
        end
    endtask

    task automatic test_fallback();
        int cnt;
        // Holding the seed load keeps every retry on edge 0 with along=10
        iSeedLoad = 1'b1;
        iSeed     = 16'h0140;
        iReq      = 1'b1;
        iReady    = 1'b0;
        cnt = 0;
        do begin
            @(posedge iClk); #1;
            cnt++;
            iReq = 1'b0;
        end while (oValid !== 1'b1 && cnt < 20);
        checks++;
        if (cnt != RETRY_MAX + 2) begin
            errors++;
            $display("FAIL fallback_latency: got %0d cycles, expected %0d", cnt, RETRY_MAX + 2);
        end
        checks++;
        if (oPosX !== 11'd320 || oPosY !== 11'd0 || oDir !== 3'd3 || oSize !== 2'd1 ||
            oFallback !== 1'b1) begin
            errors++;
            $display("FAIL fallback_result: got x=%0d y=%0d dir=%0d size=%0d fb=%b, expected x=320 y=0 dir=3 size=1 fb=1",
                     oPosX, oPosY, oDir, oSize, oFallback);
        end
        iSeedLoad = 1'b0;
        iReady    = 1'b1;
        @(posedge iClk); #1;
        iReady = 1'b0;
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL fallback_release: got valid=%b, expected 0", oValid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int pairs;
        int edges;
        n = 0;
        iReq   = 1'b1;
        iReady = 1'b1;
        @(posedge iClk); #1;
        while (1) begin
            run_spawn(0, ($urandom_range(0, 15) == 0), "b2b");
            n++;
            if (n >= N_B2B || errors > 20) begin
                iReq = 1'b0;
                break;
            end
            @(posedge iClk); #1;
        end
        iReady = 1'b0;
        edges = 0;
        pairs = 0;
        for (int e = 0; e < 4; e++) begin
            if (edge_hit[e]) edges++;
            for (int d = 0; d < 8; d++) if (pair_hit[e][d]) pairs++;
        end
        checks++;
        if (edges != 4) begin
            errors++;
            $display("FAIL edge_coverage: got %0d edges hit, expected 4", edges);
        end
        checks++;
        if (pairs != 8) begin
            errors++;
            $display("FAIL pair_coverage: got %0d edge/dir pairs hit, expected 8", pairs);
        end
    endtask

    task automatic test_reset_abort();
        int cnt;
        bit quiet;
        // Reset while drawing
        iReq = 1'b1;
        @(posedge iClk); #1;
        iReq = 1'b0;
        iRst = 1'b0;
        #1;
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL abort_draw: got valid=%b x=%0d y=%0d, expected all 0", oValid, oPosX, oPosY);
        end
        @(posedge iClk); #1;
        iRst = 1'b1;
        quiet = 1;
        for (int i = 0; i < RETRY_MAX + 5; i++) begin
            @(posedge iClk); #1;
            if (oValid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL abort_draw_quiet: got a valid result after reset, expected none");
        end
        // Reset while holding a result
        iReq = 1'b1;
        @(posedge iClk); #1;
        iReq = 1'b0;
        cnt = 0;
        while (oValid !== 1'b1 && cnt < RETRY_MAX + 3) begin
            @(posedge iClk); #1;
            cnt++;
        end
        checks++;
        if (oValid !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold_reach: got valid=%b, expected 1", oValid);
        end
        iRst = 1'b0;
        #1;
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL abort_hold: got valid=%b x=%0d y=%0d dir=%0d, expected all 0",
                     oValid, oPosX, oPosY, oDir);
        end
        @(posedge iClk); #1;
        iRst = 1'b1;
        // First draw after release follows the sequence from SEED
        iReq = 1'b1;
        @(posedge iClk); #1;
        iReq = 1'b0;
        run_spawn(2, 1'b0, "post_reset");
        iReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seed_load();
        test_handshake();
        test_fallback();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
